fifo_frame_ctrl: RTL and testbench
==================================

# fifo_frame_ctrl

Parametrised frame-capture and burst-drain controller between the FFT sample source and the MCU/UART readout path. On host request it captures one contiguous frame of samples into an internal buffer, then streams the frame out over a valid/ready interface with a last-beat marker. It supports runtime frame length, abort on host withdrawal, an optional continuous re-arm mode and frame/abort status. Single clock domain; the source, the buffer and the readout all run on `clk`.

## Interface
Parameters:
- DATA_W, 14, sample width
- DEPTH, 1024, buffer depth in samples; power of two, ≥ 4
- CONTINUOUS, 0, 1 = re-arm capture after each drained frame while rx_ready stays high

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_ready  in  1  host requests frames; low = stop/abort
- data_valid  in  1  source sample valid
- data_in  in  DATA_W  source sample
- frame_len  in  $clog2(DEPTH)+1  samples per frame; sampled at capture start
- out_valid  out  1  readout beat valid
- out_ready  in  1  readout sink accepts beat
- out_data  out  DATA_W  readout sample
- out_last  out  1  high on the final beat of a frame
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse when the last beat is accepted
- abort  out  1  one-cycle pulse when a frame is abandoned
- frame_cnt  out  16  completed frames, wraps at 2^16

## Operation
- Reset: state IDLE; out_valid, out_last, busy, frame_done, abort = 0; out_data = 0; frame_cnt = 0; write/read counters = 0.
- Effective length L = frame_len, except 0 or > DEPTH gives L = DEPTH. L is latched at capture start and is fixed for that frame.
- IDLE: when rx_ready & data_valid, latch L, write data_in at address 0 in the same cycle, and go to FILL. If L = 1, go straight to DRAIN.
- FILL: each cycle with data_valid = 1, write data_in at wr_cnt and increment wr_cnt. A data_valid gap writes nothing and does not count. The write of index L-1 moves the state to DRAIN.
- DRAIN: read indices 0..L-1 in order. Each beat is transferred on out_valid & out_ready. out_data and out_last stay stable while out_valid & !out_ready. out_last = 1 only on index L-1.
- On the last beat accepted: pulse frame_done, increment frame_cnt, then:
  - if CONTINUOUS = 1 and rx_ready = 1, go to IDLE-equivalent re-arm: capture restarts on the next data_valid.
  - otherwise go to HOLD.
- HOLD: wait for rx_ready = 0, then go to IDLE. No new capture starts until rx_ready has been low at least one cycle.
- Abort: rx_ready = 0 in FILL or DRAIN causes, on the next edge:
  - state IDLE, one-cycle abort pulse, out_valid = 0, counters cleared
  - frame_cnt unchanged
  - a beat accepted in that same cycle still counts as transferred, but frame_done does not fire unless it was the last beat.
- Abort and last-beat acceptance in the same cycle: frame_done wins, then HOLD/IDLE per rx_ready. abort does not pulse.
- Buffer contents are undefined after abort. Readout never returns data from a previous frame.

## Timing
- Capture accepts one sample per cycle with no stalls; data_valid has no backpressure.
- If the last sample is written at cycle T: state = DRAIN at T+1, and out_valid first rises at T+2 with index 0 (one-cycle registered RAM read).
- Throughput: one beat per cycle while out_ready = 1. No bubbles between beats of a frame.
- out_valid falls the cycle after the last beat is accepted.
- frame_done and frame_cnt update on the edge after the last-beat handshake.
- Minimum frame-to-frame gap in CONTINUOUS mode: capture of the next frame may begin the cycle after frame_done.

## Structure
- Package fifo_frame_pkg holds:
  - the state enum (IDLE, FILL, DRAIN, HOLD)
  - a function for effective frame length
  - the frame_cnt width constant (16)
- Sub-module frame_ram: simple dual-port RAM, DATA_W × DEPTH, one write port, one read port with read-enable and registered output (q holds when read-enable is low).
- fifo_frame_ctrl contains the FSM, wr_cnt/rd_cnt ($clog2(DEPTH)+1 bits), the output valid/last registers and status.

## Test plan
- DEPTH=16, frame_len=8, data_valid constant, data_in = 0..7, out_ready=1 → out_data 0..7 on 8 consecutive cycles, out_last on 7, frame_done once, frame_cnt = 1, state HOLD until rx_ready drops.
- frame_len=0 and frame_len=20 with DEPTH=16 → exactly 16 beats, out_last on beat 15.
- data_valid toggling 1,0,1,0 during FILL → only valid samples stored; readout sequence contiguous, no duplicates.
- Random out_ready with 30% stalls → out_data and out_last stable during stalls; exact sequence 0..L-1 delivered.
- rx_ready dropped mid-FILL (after 3 samples) and mid-DRAIN (after 2 beats) → abort pulse, out_valid = 0 next cycle, frame_cnt unchanged; next request captures a fresh frame.
- CONTINUOUS=1, rx_ready held high, 3 frames → frame_cnt = 3, back-to-back captures; rst asserted mid-DRAIN → all outputs at reset values immediately.

Source files
------------

// File: rtl/fifo_frame_pkg.sv
// Shared types and helpers for the frame-capture / burst-drain controller.
package fifo_frame_pkg;

  // Width of the completed-frame counter; wraps naturally.
  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  // A requested length of zero, or one larger than the buffer, means a full buffer.
  function automatic int unsigned eff_frame_len(input int unsigned len,
                                                input int unsigned depth);
    return ((len == 0) || (len > depth)) ? depth : len;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered output that holds its value while the read enable is low.
module frame_ram #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        q_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] q_q;

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; cleared by reset so the readout bus starts at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (re_i) begin
      q_q <= mem_q[raddr_i];
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fifo_frame_ctrl.sv
// Frame-capture and burst-drain controller: captures one contiguous frame
// from the sample source into frame_ram, then streams it out over a
// valid/ready interface with a last-beat marker.
module fifo_frame_ctrl
  import fifo_frame_pkg::*;
#(
  parameter int unsigned DATA_W     = 14,
  parameter int unsigned DEPTH      = 1024,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_ready,
  input  logic                   data_valid,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [$clog2(DEPTH):0] frame_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   abort,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  state_e                 state_q;
  logic [CW-1:0]          len_q;
  logic [CW-1:0]          wr_cnt_q;
  logic [CW-1:0]          rd_cnt_q;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic                   busy_q;
  logic                   frame_done_q;
  logic                   abort_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic [CW-1:0]          len_eff;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic                   rd_en;
  logic                   last_acc;

  assign len_eff = CW'(eff_frame_len(32'(frame_len), DEPTH));

  // Buffer strobes. A read is issued whenever the output register is empty
  // or is being consumed this cycle, which gives one beat per cycle with no
  // bubbles and keeps out_data stable while the sink stalls.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = '0;
    rd_en    = 1'b0;
    last_acc = 1'b0;
    if (rx_ready && data_valid) begin
      if (state_q == IDLE) begin
        wr_en   = 1'b1;
        wr_addr = '0;
      end else if (state_q == FILL) begin
        wr_en   = 1'b1;
        wr_addr = wr_cnt_q[AW-1:0];
      end
    end
    if (state_q == DRAIN) begin
      last_acc = out_valid_q && out_ready && out_last_q;
      rd_en    = rx_ready && (rd_cnt_q < len_q) && (!out_valid_q || out_ready);
    end
  end

  frame_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (data_in),
    .re_i    (rd_en),
    .raddr_i (rd_cnt_q[AW-1:0]),
    .q_o     (out_data)
  );

  // Control FSM with registered valid/last and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_ready && data_valid) begin
            len_q    <= len_eff;
            wr_cnt_q <= CW'(1);
            rd_cnt_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= (len_eff == CW'(1)) ? DRAIN : FILL;
          end
        end

        FILL: begin
          if (!rx_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            abort_q     <= 1'b1;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else if (data_valid) begin
            wr_cnt_q <= wr_cnt_q + CW'(1);
            if (wr_cnt_q == len_q - CW'(1)) begin
              state_q <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // Completing the frame takes priority over a same-cycle withdrawal.
          if (last_acc) begin
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + FRAME_CNT_W'(1);
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            if (rx_ready && !CONTINUOUS) begin
              state_q <= HOLD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (!rx_ready) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            abort_q     <= 1'b1;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else if (rd_en) begin
            rd_cnt_q    <= rd_cnt_q + CW'(1);
            out_valid_q <= 1'b1;
            out_last_q  <= (rd_cnt_q == len_q - CW'(1));
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end

        HOLD: begin
          if (!rx_ready) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign abort      = abort_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_ctrl.sv
// Directed bench for fifo_frame_ctrl (DEPTH=16): a one-shot instance and a
// continuous re-arm instance share the stimulus inputs.
module tb_fifo_frame_ctrl;

  localparam int unsigned DATA_W = 14;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_ready;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic [CW-1:0]     frame_len;
  logic              out_ready;

  logic              out_valid, out_last, busy, frame_done, abort;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       frame_cnt;

  logic              c_out_valid, c_out_last, c_busy, c_frame_done, c_abort;
  logic [DATA_W-1:0] c_out_data;
  logic [15:0]       c_frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] got_data [64];
  logic              got_last [64];
  int                got_n;
  int                got_cyc;
  int                unstable;

  always #5 clk = ~clk;

  fifo_frame_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CONTINUOUS(1'b0)) dut (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .data_valid(data_valid),
    .data_in(data_in), .frame_len(frame_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .frame_done(frame_done), .abort(abort), .frame_cnt(frame_cnt)
  );

  fifo_frame_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CONTINUOUS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .rx_ready(rx_ready), .data_valid(data_valid),
    .data_in(data_in), .frame_len(frame_len), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_data(c_out_data), .out_last(c_out_last),
    .busy(c_busy), .frame_done(c_frame_done), .abort(c_abort), .frame_cnt(c_frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n consecutive samples base, base+1, ...; with gaps a junk value is
  // presented with data_valid low before every real sample.
  task automatic fill(input int n, input int base, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        data_valid = 1'b0;
        data_in    = '1;
        tick();
      end
      data_valid = 1'b1;
      data_in    = DATA_W'(base + k);
      tick();
    end
    data_valid = 1'b0;
    data_in    = '0;
  endtask

  // Record accepted beats of the one-shot instance until the last beat is taken.
  task automatic collect(input int max_cyc, input int stall_pct);
    logic              prev_stall;
    logic [DATA_W-1:0] pd;
    logic              pl;
    bit                saw_last;
    got_n = 0; got_cyc = 0; unstable = 0;
    prev_stall = 1'b0; pd = '0; pl = 1'b0; saw_last = 1'b0;
    for (int c = 0; c < max_cyc && !saw_last && got_n < 64; c++) begin
      if (prev_stall && (out_valid !== 1'b1 || out_data !== pd || out_last !== pl))
        unstable++;
      out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99, 0) >= stall_pct);
      if (out_valid === 1'b1 && out_ready) begin
        got_data[got_n] = out_data;
        got_last[got_n] = out_last;
        if (out_last === 1'b1) saw_last = 1'b1;
        got_n++;
      end
      prev_stall = (out_valid === 1'b1) && !out_ready;
      pd = out_data;
      pl = out_last;
      got_cyc++;
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic release_host();
    rx_ready = 1'b0;
    tick();
    rx_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_ready = 1'b0; data_valid = 1'b0; data_in = '0;
    frame_len = '0; out_ready = 1'b1;
    tick(); tick();
    n_checks++;
    if ({out_valid, out_last, busy, frame_done, abort} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {out_valid, out_last, busy, frame_done, abort});
    end
    n_checks++;
    if (out_data !== '0 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_data_cnt: got data %h cnt %0d expected 0 0", out_data, frame_cnt);
    end
    n_checks++;
    if ({c_out_valid, c_busy, c_frame_cnt} !== 18'd0) begin
      n_fail++; $display("FAIL reset_cont: got %h expected 0", {c_out_valid, c_busy, c_frame_cnt});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_basic();
    int  errs;
    bit  seen_valid;
    frame_len = CW'(8); rx_ready = 1'b1;
    fill(8, 'h100, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_drain_entry: got busy %b valid %b expected 1 0", busy, out_valid);
    end
    collect(40, 0);
    n_checks++;
    if (got_n !== 8) begin
      n_fail++; $display("FAIL basic_beats: got %0d expected 8", got_n);
    end
    errs = 0;
    for (int k = 0; k < 8; k++)
      if (got_data[k] !== DATA_W'('h100 + k) || got_last[k] !== (k == 7)) errs++;
    n_checks++;
    if (errs != 0) begin
      n_fail++; $display("FAIL basic_seq: got %0d wrong beats expected 0", errs);
    end
    n_checks++;
    if (got_cyc !== 9) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles expected 9", got_cyc);
    end
    n_checks++;
    if (frame_done !== 1'b1 || frame_cnt !== 16'd1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: got done %b cnt %0d valid %b expected 1 1 0", frame_done, frame_cnt, out_valid);
    end
    data_valid = 1'b1; data_in = 'h5; seen_valid = 1'b0;
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", frame_done);
    end
    for (int k = 0; k < 12; k++) begin
      if (out_valid === 1'b1) seen_valid = 1'b1;
      tick();
    end
    n_checks++;
    if (seen_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_hold: got valid_seen %b busy %b expected 0 1", seen_valid, busy);
    end
    data_valid = 1'b0; rx_ready = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold_exit: got busy %b expected 0", busy);
    end
    rx_ready = 1'b1;
  endtask

  task automatic test_len_boundary();
    int errs;
    int lens [2] = '{0, 20};
    for (int i = 0; i < 2; i++) begin
      frame_len = CW'(lens[i]);
      fill(16, 'h200 + 'h40 * i, 1'b0);
      collect(60, 0);
      errs = 0;
      for (int k = 0; k < 16; k++)
        if (got_data[k] !== DATA_W'('h200 + 'h40 * i + k) || got_last[k] !== (k == 15)) errs++;
      n_checks++;
      if (got_n !== 16 || errs != 0) begin
        n_fail++; $display("FAIL len_%0d: got %0d beats %0d wrong expected 16 0", lens[i], got_n, errs);
      end
      release_host();
    end
    frame_len = CW'(1);
    fill(1, 'h3AB, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL len1_entry: got busy %b valid %b expected 1 0", busy, out_valid);
    end
    collect(20, 0);
    n_checks++;
    if (got_n !== 1 || got_data[0] !== DATA_W'('h3AB) || got_last[0] !== 1'b1 || got_cyc !== 2) begin
      n_fail++; $display("FAIL len1: got n %0d data %h last %b cyc %0d expected 1 3ab 1 2", got_n, got_data[0], got_last[0], got_cyc);
    end
    release_host();
    n_checks++;
    if (frame_cnt !== 16'd4) begin
      n_fail++; $display("FAIL len_cnt: got %0d expected 4", frame_cnt);
    end
  endtask

  task automatic test_gaps();
    int errs;
    frame_len = CW'(6);
    fill(6, 'h050, 1'b1);
    collect(40, 0);
    errs = 0;
    for (int k = 0; k < 6; k++)
      if (got_data[k] !== DATA_W'('h050 + k) || got_last[k] !== (k == 5)) errs++;
    n_checks++;
    if (got_n !== 6 || errs != 0) begin
      n_fail++; $display("FAIL gaps_seq: got %0d beats %0d wrong expected 6 0", got_n, errs);
    end
    release_host();
  endtask

  task automatic test_stalls();
    int errs;
    frame_len = CW'(12);
    fill(12, 'h1C0, 1'b0);
    collect(200, 30);
    errs = 0;
    for (int k = 0; k < 12; k++)
      if (got_data[k] !== DATA_W'('h1C0 + k) || got_last[k] !== (k == 11)) errs++;
    n_checks++;
    if (got_n !== 12 || errs != 0) begin
      n_fail++; $display("FAIL stall_seq: got %0d beats %0d wrong expected 12 0", got_n, errs);
    end
    n_checks++;
    if (unstable !== 0) begin
      n_fail++; $display("FAIL stall_stable: got %0d changes expected 0", unstable);
    end
    n_checks++;
    if (frame_cnt !== 16'd6) begin
      n_fail++; $display("FAIL stall_cnt: got %0d expected 6", frame_cnt);
    end
    release_host();
  endtask

  task automatic test_abort();
    int errs;
    // withdrawal during capture
    frame_len = CW'(8);
    fill(3, 'h0AA, 1'b0);
    rx_ready = 1'b0;
    tick();
    n_checks++;
    if (abort !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || frame_cnt !== 16'd6) begin
      n_fail++; $display("FAIL abort_fill: got abort %b busy %b valid %b cnt %0d expected 1 0 0 6", abort, busy, out_valid, frame_cnt);
    end
    tick();
    n_checks++;
    if (abort !== 1'b0) begin
      n_fail++; $display("FAIL abort_pulse: got %b expected 0", abort);
    end
    rx_ready = 1'b1; frame_len = CW'(4);
    fill(4, 'h0D0, 1'b0);
    collect(40, 0);
    errs = 0;
    for (int k = 0; k < 4; k++)
      if (got_data[k] !== DATA_W'('h0D0 + k) || got_last[k] !== (k == 3)) errs++;
    n_checks++;
    if (got_n !== 4 || errs != 0 || frame_cnt !== 16'd7) begin
      n_fail++; $display("FAIL abort_fill_next: got %0d beats %0d wrong cnt %0d expected 4 0 7", got_n, errs, frame_cnt);
    end
    release_host();

    // withdrawal after two accepted beats
    frame_len = CW'(8);
    fill(8, 'h120, 1'b0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== DATA_W'('h122)) begin
      n_fail++; $display("FAIL abort_drain_pre: got valid %b data %h expected 1 122", out_valid, out_data);
    end
    out_ready = 1'b0; rx_ready = 1'b0;
    tick();
    n_checks++;
    if (abort !== 1'b1 || out_valid !== 1'b0 || frame_done !== 1'b0 || frame_cnt !== 16'd7) begin
      n_fail++; $display("FAIL abort_drain: got abort %b valid %b done %b cnt %0d expected 1 0 0 7", abort, out_valid, frame_done, frame_cnt);
    end
    out_ready = 1'b1;
    tick();
    rx_ready = 1'b1; frame_len = CW'(5);
    fill(5, 'h140, 1'b0);
    collect(40, 0);
    errs = 0;
    for (int k = 0; k < 5; k++)
      if (got_data[k] !== DATA_W'('h140 + k) || got_last[k] !== (k == 4)) errs++;
    n_checks++;
    if (got_n !== 5 || errs != 0 || frame_cnt !== 16'd8) begin
      n_fail++; $display("FAIL abort_drain_next: got %0d beats %0d wrong cnt %0d expected 5 0 8", got_n, errs, frame_cnt);
    end
    release_host();

    // withdrawal in the same cycle as the last beat
    frame_len = CW'(3);
    fill(3, 'h160, 1'b0);
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== DATA_W'('h162)) begin
      n_fail++; $display("FAIL abort_last_pre: got valid %b last %b data %h expected 1 1 162", out_valid, out_last, out_data);
    end
    rx_ready = 1'b0;
    tick();
    n_checks++;
    if (frame_done !== 1'b1 || abort !== 1'b0 || frame_cnt !== 16'd9) begin
      n_fail++; $display("FAIL abort_last: got done %b abort %b cnt %0d expected 1 0 9", frame_done, abort, frame_cnt);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || abort !== 1'b0) begin
      n_fail++; $display("FAIL abort_last_idle: got busy %b abort %b expected 0 0", busy, abort);
    end
    rx_ready = 1'b1;
  endtask

  task automatic test_continuous();
    int                dcnt;
    int                errs;
    bit                stop;
    logic [DATA_W-1:0] nxt;
    rst = 1'b1;
    tick();
    rst = 1'b0; rx_ready = 1'b1; out_ready = 1'b1; frame_len = CW'(4);
    data_valid = 1'b1; dcnt = 1; got_n = 0; got_cyc = 0; stop = 1'b0;
    for (int c = 0; c < 100 && !stop; c++) begin
      data_in = DATA_W'(dcnt);
      dcnt++;
      if (c_out_valid === 1'b1) begin
        got_data[got_n] = c_out_data;
        got_last[got_n] = c_out_last;
        got_n++;
        if (got_n == 12) stop = 1'b1;
      end
      got_cyc++;
      tick();
    end
    n_checks++;
    if (got_n !== 12 || c_frame_cnt !== 16'd3 || c_frame_done !== 1'b1) begin
      n_fail++; $display("FAIL cont_frames: got beats %0d cnt %0d done %b expected 12 3 1", got_n, c_frame_cnt, c_frame_done);
    end
    errs = 0;
    for (int k = 0; k < 12; k++) begin
      if (got_last[k] !== ((k % 4) == 3)) errs++;
      if (k > 0) begin
        nxt = got_data[k-1] + 1'b1;
        if ((k % 4) != 0 && got_data[k] !== nxt) errs++;
        if ((k % 4) == 0 && got_data[k] <= got_data[k-1]) errs++;
      end
    end
    n_checks++;
    if (errs != 0) begin
      n_fail++; $display("FAIL cont_seq: got %0d errors expected 0", errs);
    end
    n_checks++;
    if (got_cyc > 30) begin
      n_fail++; $display("FAIL cont_rearm: got %0d cycles expected at most 30", got_cyc);
    end
    for (int c = 0; c < 40 && c_out_valid !== 1'b1; c++) begin
      data_in = DATA_W'(dcnt);
      dcnt++;
      tick();
    end
    n_checks++;
    if (c_out_valid !== 1'b1) begin
      n_fail++; $display("FAIL cont_drain_wait: got valid %b expected 1", c_out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({c_out_valid, c_out_last, c_busy, c_frame_done, c_abort} !== 5'b0 ||
        c_out_data !== '0 || c_frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL cont_async_rst: got flags %b data %h cnt %0d expected 00000 0 0",
                         {c_out_valid, c_out_last, c_busy, c_frame_done, c_abort}, c_out_data, c_frame_cnt);
    end
    n_checks++;
    if (busy !== 1'b0 || frame_cnt !== 16'd0) begin
      n_fail++; $display("FAIL oneshot_async_rst: got busy %b cnt %0d expected 0 0", busy, frame_cnt);
    end
    data_valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_boundary();
    test_gaps();
    test_stalls();
    test_abort();
    test_continuous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
